div_sequencer: RTL

- Multi-cycle control stage in front of the combinational 32-bit unsigned divider (DIV32).
- Accepts a DIV request from the ALU/control unit and converts signed operands to magnitudes.
- Drives the divider inputs from registers, held stable for a fixed multicycle settle window, then captures quotient and remainder.
- Applies sign correction, writes the results to the LO (quotient) and HI (remainder) registers, and handles divide-by-zero without using the divider.

---
 rtl/div_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// Multicycle control stage for a combinational unsigned divider: sign handling,
// registered operand drive with a fixed settle window, and result capture.
module div_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oLO,
    output logic [WIDTH-1:0] oHI,
    output logic             oDivZero,
    output logic [WIDTH-1:0] oDivQ,
    output logic [WIDTH-1:0] oDivD,
    input  logic [WIDTH-1:0] iDivQ,
    input  logic [WIDTH-1:0] iDivR
);

    // state  | meaning
    // IDLE   | waiting for iStart; operands latched on the accepting edge
    // SETTLE | divider inputs held; counter runs down to the capture edge
    // DONE   | results valid, oDone high for this single cycle

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            neg_q;
    logic            neg_r;

    logic            a_neg;
    logic            b_neg;
    assign a_neg = iSigned & iA[WIDTH-1];
    assign b_neg = iSigned & iB[WIDTH-1];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= IDLE;
            count    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oLO      <= '0;
            oHI      <= '0;
            oDivZero <= 1'b0;
            oDivQ    <= '0;
            oDivD    <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        oDivQ <= a_neg ? -iA : iA;
                        oDivD <= b_neg ? -iB : iB;
                        oBusy <= 1'b1;
                        // Divide-by-zero bypasses the divider entirely.
                        if (iB == '0) begin
                            oLO      <= '1;
                            oHI      <= iA;
                            oDivZero <= 1'b1;
                            oDone    <= 1'b1;
                            state    <= DONE;
                        end else begin
                            count <= CW'(SETTLE_CYCLES - 1);
                            state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (count == '0) begin
                        oLO      <= neg_q ? -iDivQ : iDivQ;
                        oHI      <= neg_r ? -iDivR : iDivR;
                        oDivZero <= 1'b0;
                        oDone    <= 1'b1;
                        state    <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
